// File: rtl/nv_async_evt_arb.sv
// Asynchronous event arbiter: synchronizes level event lines, detects rising edges
// and presents pending events round-robin on a valid/ready port.
// Optional per-event overflow flags: define NV_EVT_ARB_OVF_DETECT_EN.

module sync3d (
    input  logic clk,
    input  logic d,
    output logic q
);
    logic [2:0] meta_q;
    logic [2:0] meta_d;

    always_comb begin
        meta_d = {meta_q[1:0], d};
    end

    // No reset on purpose: contents are masked downstream until they have flushed.
    always_ff @(posedge clk) begin
        meta_q <= meta_d;
    end

    assign q = meta_q[2];
endmodule

module nv_async_evt_arb #(
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic [NUM_EVT-1:0] evt_in,
    output logic               evt_vld,
    output logic [IDX_W-1:0]   evt_idx,
    input  logic               evt_rdy,
    output logic [NUM_EVT-1:0] evt_pend,
    output logic [NUM_EVT-1:0] evt_ovf,
    input  logic               ovf_clr
);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0]   NUM_EVT_S = SUM_W'(NUM_EVT);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_EVT - 1);
    localparam logic [NUM_EVT-1:0] ONE_HOT0  = NUM_EVT'(1);

    logic [NUM_EVT-1:0] sync_c;
    logic [NUM_EVT-1:0] rise_c;
    logic [NUM_EVT-1:0] clr_c;
    logic [NUM_EVT-1:0] rot_c;
    logic [IDX_W-1:0]   off_c;
    logic [SUM_W-1:0]   sum_c;
    logic [IDX_W-1:0]   win_c;
    logic               load_c;

    logic [NUM_EVT-1:0] hist_q, hist_d;
    logic [NUM_EVT-1:0] pend_q, pend_d;
    logic [1:0]         warm_q, warm_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_sync
        sync3d u_sync (
            .clk (nvdla_core_clk),
            .d   (evt_in[g]),
            .q   (sync_c[g])
        );
    end

    // Edge detect, gated until the synchronizers have flushed after reset.
    always_comb begin
        hist_d = sync_c;
        warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        rise_c = (warm_q == 2'd3) ? (sync_c & ~hist_q) : '0;
    end

    // Round-robin pick: rotate pend so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_c = NUM_EVT'({pend_q, pend_q} >> rr_q);
        off_c = '0;
        for (int k = NUM_EVT - 1; k >= 0; k--) begin
            if (rot_c[k]) off_c = IDX_W'(k);
        end
        sum_c = {1'b0, rr_q} + {1'b0, off_c};
        if (sum_c >= NUM_EVT_S) sum_c = sum_c - NUM_EVT_S;
        win_c = sum_c[IDX_W-1:0];
    end

    always_comb begin
        load_c = (~vld_q | evt_rdy) & (|pend_q);
        clr_c  = load_c ? (ONE_HOT0 << win_c) : '0;
        vld_d  = vld_q;
        idx_d  = idx_q;
        rr_d   = rr_q;
        if (load_c) begin
            vld_d = 1'b1;
            idx_d = win_c;
            rr_d  = (win_c == LAST_IDX) ? '0 : win_c + IDX_W'(1);
        end else if (vld_q & evt_rdy) begin
            vld_d = 1'b0;
        end
        // A rise on the bit being granted re-arms it, so no event is dropped.
        pend_d = (pend_q & ~clr_c) | rise_c;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hist_q <= '0;
            pend_q <= '0;
            warm_q <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            rr_q   <= '0;
        end else begin
            hist_q <= hist_d;
            pend_q <= pend_d;
            warm_q <= warm_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            rr_q   <= rr_d;
        end
    end

    assign evt_vld  = vld_q;
    assign evt_idx  = idx_q;
    assign evt_pend = pend_q;

`ifdef NV_EVT_ARB_OVF_DETECT_EN
    logic [NUM_EVT-1:0] ovf_q, ovf_d;
    logic [NUM_EVT-1:0] ovf_set_c;

    // A set in the same cycle as a clear wins.
    always_comb begin
        ovf_set_c = rise_c & pend_q & ~clr_c;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_set_c;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign evt_ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign evt_ovf        = '0;
`endif

endmodule

// File: tb/tb_nv_async_evt_arb.sv
// Bench for nv_async_evt_arb: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.

module tb_nv_async_evt_arb;
`ifdef NV_EVT_ARB_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int N = 4;
    localparam logic [3:0] OVF1   = OVF_EN ? 4'b0010 : 4'b0000;
    localparam logic [3:0] OVF12  = OVF_EN ? 4'b0110 : 4'b0000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] evt_in;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [1:0] idx;
    logic [3:0] pend;
    logic [3:0] ovf;

    nv_async_evt_arb #(.NUM_EVT(4), .IDX_W(2)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .evt_in          (evt_in),
        .evt_vld         (vld),
        .evt_idx         (idx),
        .evt_rdy         (rdy),
        .evt_pend        (pend),
        .evt_ovf         (ovf),
        .ovf_clr         (clr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int hs0         = 0;

    // Behavioural model state (plain integers).
    int m_q[$];
    int m_hist, m_warm, m_pend, m_rr, m_vld, m_idx, m_ovf;

    typedef struct {
        logic [3:0] in;
        logic       rdy;
        logic       vld;
        logic [1:0] idx;
        logic [3:0] pend;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] in, logic r, logic v, logic [1:0] i, logic [3:0] p);
        vec_t t;
        t.in = in; t.rdy = r; t.vld = v; t.idx = i; t.pend = p;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hist = 0; m_warm = 0; m_pend = 0; m_rr = 0; m_vld = 0; m_idx = 0; m_ovf = 0;
    endtask

    // Advance the model by one rising edge, using the inputs about to be sampled.
    task automatic model_edge();
        int sync, rise, w, c, after;
        sync = (m_q.size() >= 3) ? m_q[2] : 0;
        if (!rstn) begin
            model_clear();
        end else begin
            rise  = (m_warm == 3) ? (sync & ~m_hist & 'hF) : 0;
            after = m_pend;
            if ((m_vld == 0 || rdy) && m_pend != 0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (w < 0 && ((m_pend >> c) & 1) == 1) w = c;
                end
                after = m_pend & ~(1 << w);
                m_vld = 1; m_idx = w; m_rr = (w + 1) % N;
            end else if (m_vld == 1 && rdy) begin
                m_vld = 0;
            end
            if (OVF_EN) m_ovf = (clr ? 0 : m_ovf) | (rise & after);
            m_pend = after | rise;
            m_hist = sync;
            if (m_warm < 3) m_warm++;
        end
        m_q.push_front(int'(evt_in));
        if (m_q.size() > 3) void'(m_q.pop_back());
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic [3:0] in, input logic r, input logic c);
        evt_in = in; rdy = r; clr = c;
        if (rstn && vld && rdy && idx == 2'd0) hs0++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] in, input logic r, input int zeros);
        step(in, r, 1'b0);
        for (int i = 0; i < zeros; i++) step(4'b0000, r, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; evt_in = 4'b1111; rdy = 1'b0; clr = 1'b0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);
        check("rst_vld",  int'(vld),  0);
        check("rst_idx",  int'(idx),  0);
        check("rst_pend", int'(pend), 0);
        check("rst_ovf",  int'(ovf),  0);

        // Lines already high at reset release never produce an event.
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            check($sformatf("hi_rel%0d_vld", i), int'(vld), 0);
            check($sformatf("hi_rel%0d_pend", i), int'(pend), 0);
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000));
        tbl.push_back(mk(4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011));
        tbl.push_back(mk(4'b1011, 1'b1, 1'b1, 2'd0, 4'b1010));
        tbl.push_back(mk(4'b1011, 1'b1, 1'b1, 2'd1, 4'b1000));
        tbl.push_back(mk(4'b1011, 1'b1, 1'b1, 2'd3, 4'b0000));
        tbl.push_back(mk(4'b1011, 1'b1, 1'b0, 2'd3, 4'b0000));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b1010, 1'b1, 1'b0, 2'd3, 4'b0000));
        tbl.push_back(mk(4'b1010, 1'b1, 1'b0, 2'd3, 4'b1010));
        tbl.push_back(mk(4'b1010, 1'b1, 1'b1, 2'd1, 4'b1000));
        tbl.push_back(mk(4'b1010, 1'b1, 1'b1, 2'd3, 4'b0000));
        tbl.push_back(mk(4'b1010, 1'b1, 1'b0, 2'd3, 4'b0000));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd3, 4'b0000));
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd3, 4'b0100));
        tbl.push_back(mk(4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000));
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd2, 4'b0000));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, tbl[i].rdy, 1'b0);
            check($sformatf("tbl%0d_vld", i),  int'(vld),  int'(tbl[i].vld));
            check($sformatf("tbl%0d_idx", i),  int'(idx),  int'(tbl[i].idx));
            check($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].pend));
        end

        // Stalled consumer: index 1 held, repeated pulses merge and flag overflow.
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 1'b0);
        check("stall_vld", int'(vld), 1);
        check("stall_idx", int'(idx), 1);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
        pulse(4'b0010, 1'b0, 5);
        check("p1_pend", int'(pend), 4'b0010);
        check("p1_ovf",  int'(ovf),  0);
        check("p1_idx",  int'(idx),  1);
        pulse(4'b0010, 1'b0, 5);
        check("p2_pend", int'(pend), 4'b0010);
        check("p2_ovf",  int'(ovf),  int'(OVF1));
        check("p2_vld",  int'(vld),  1);
        check("p2_idx",  int'(idx),  1);
        step(4'b0000, 1'b0, 1'b1);
        check("clr_ovf", int'(ovf), 0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("setclr_ovf", int'(ovf), int'(OVF1));
        step(4'b0000, 1'b0, 1'b1);
        check("clr2_ovf", int'(ovf), 0);
        step(4'b0000, 1'b1, 1'b0);
        check("drain_vld",  int'(vld),  1);
        check("drain_idx",  int'(idx),  1);
        check("drain_pend", int'(pend), 0);
        step(4'b0000, 1'b1, 1'b0);
        check("drain_off", int'(vld), 0);

        // Rise on bit 0 on the very edge its pending bit is granted.
        pulse(4'b0010, 1'b0, 4);
        check("c_hold_vld", int'(vld), 1);
        check("c_hold_idx", int'(idx), 1);
        pulse(4'b0001, 1'b0, 4);
        check("c_pend0", int'(pend), 4'b0001);
        hs0 = 0;
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("c_vld",  int'(vld),  1);
        check("c_idx",  int'(idx),  0);
        check("c_pend", int'(pend), 4'b0001);
        step(4'b0000, 1'b1, 1'b0);
        check("c2_idx",  int'(idx),  0);
        check("c2_pend", int'(pend), 0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("c_hs0_count", hs0, 2);

        // Asynchronous reset mid-handshake with events pending.
        pulse(4'b0001, 1'b0, 4);
        check("ar_vld_pre", int'(vld), 1);
        pulse(4'b0110, 1'b0, 4);
        pulse(4'b0110, 1'b0, 4);
        check("ar_pend_pre", int'(pend), 4'b0110);
        check("ar_ovf_pre",  int'(ovf),  int'(OVF12));
        #2 rstn = 1'b0;
        model_clear();
        #1;
        check("ar_vld",  int'(vld),  0);
        check("ar_pend", int'(pend), 0);
        check("ar_ovf",  int'(ovf),  0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] nin;
            logic       r;
            int         mode;
            mode = (i / 256) % 3;
            nin  = evt_in ^ (4'($urandom) & 4'($urandom));
            case (mode)
                0:       r = ($urandom_range(0, 7) != 0);
                1:       r = ($urandom_range(0, 1) != 0);
                default: r = ($urandom_range(0, 7) == 0);
            endcase
            step(nin, r, $urandom_range(0, 15) == 0);
            check($sformatf("rnd%0d_vld", i),  int'(vld),  m_vld);
            check($sformatf("rnd%0d_idx", i),  int'(idx),  m_idx);
            check($sformatf("rnd%0d_pend", i), int'(pend), m_pend);
            check($sformatf("rnd%0d_ovf", i),  int'(ovf),  m_ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nv_async_evt_arb.md
NV_ASYNC_EVT_ARB -- requirements
Module: nv_async_evt_arb

Interface
REQ-001 Parameter NUM_EVT, default 4: number of asynchronous event inputs; legal range 2..16.
REQ-002 Parameter IDX_W, default 2: width of the event index; SHALL equal ceil(log2(NUM_EVT)).
REQ-003 nvdla_core_clk  input  1  sole clock; all state is rising-edge triggered.
REQ-004 nvdla_core_rstn  input  1  asynchronous, active-low reset.
REQ-005 evt_in  input  NUM_EVT  asynchronous level event lines; a 0->1 transition is one event.
REQ-006 evt_vld  output  1  granted event is presented.
REQ-007 evt_idx  output  IDX_W  index of the presented event.
REQ-008 evt_rdy  input  1  consumer accepts the presented event.
REQ-009 evt_pend  output  NUM_EVT  pending-event bitmap, for debug.
REQ-010 evt_ovf  output  NUM_EVT  sticky per-event overflow flags.
REQ-011 ovf_clr  input  1  synchronous clear of all evt_ovf bits.

Function
REQ-012 Each evt_in bit SHALL pass through one 3-flop non-reset synchronizer cell (sync3d) to produce sync[i].
REQ-013 A history register hist SHALL capture sync every cycle; rise[i] = sync[i] & ~hist[i].
REQ-014 A 2-bit warm-up counter SHALL count 0..3 after reset release and saturate; rise SHALL be ignored while the counter is below 3.
REQ-015 rise[i] SHALL set pend[i] on the next edge; evt_pend SHALL equal pend.
REQ-016 Output register load condition: (~evt_vld | evt_rdy) & (|pend).
REQ-017 On load, the winner SHALL be the first set pend bit at or above rr_ptr, searching cyclically; evt_idx = winner; evt_vld = 1; pend[winner] cleared; rr_ptr = (winner+1) mod NUM_EVT.
REQ-018 If evt_vld & evt_rdy and pend is empty, evt_vld SHALL clear on the next edge; evt_idx SHALL hold its last value.
REQ-019 evt_vld SHALL stay high, and evt_idx SHALL stay stable, until evt_rdy is sampled high.
REQ-020 If rise[i] coincides with the load clearing pend[i], pend[i] SHALL remain set; no event is lost.
REQ-021 rise[i] while pend[i] is set and not being cleared is an overflow; the event merges and pend stays 1.
REQ-022 Latency: evt_in stable high before edge E0, output idle, no competitors -> evt_vld high after edge E4.
REQ-023 Throughput: one event per cycle when evt_rdy is held high.

Reset
REQ-024 While nvdla_core_rstn is low, the following SHALL be 0: evt_vld, evt_idx, pend, hist, rr_ptr, warm-up counter, and evt_ovf.
REQ-025 Reset asserted mid-handshake SHALL immediately drop evt_vld and discard all pending events.
REQ-026 Synchronizer flops have no reset; the warm-up counter masks their unknown contents.

Configuration
REQ-027 Macro NV_EVT_ARB_OVF_DETECT_EN: when defined, an overflow per REQ-021 SHALL set evt_ovf[i] on the next edge.
REQ-028 With NV_EVT_ARB_OVF_DETECT_EN defined, ovf_clr SHALL clear all evt_ovf bits; a set and a clear in the same cycle resolve to set.
REQ-029 Without NV_EVT_ARB_OVF_DETECT_EN, evt_ovf SHALL be tied to 0, ovf_clr SHALL be ignored, and no overflow logic is synthesized.

Verification
REQ-030 Reset release with evt_in=4'b1111 held high -> no event is ever presented; evt_pend stays 0.
REQ-031 evt_in[2] rises before E0, evt_rdy=1 -> evt_vld high after E4 with evt_idx=2, low after E5.
REQ-032 evt_in=4'b1011 all rise together, evt_rdy=1 -> evt_idx sequence is 0, 1, 3 on consecutive cycles; rr_ptr ends at 0.
REQ-033 evt_rdy=0 with idx 1 presented, then evt_in[1] pulses twice -> evt_idx stays 1; second pulse sets evt_ovf[1] (macro on) or leaves it 0 (macro off).
REQ-034 Rise on bit 0 in the same cycle its pend bit is consumed -> event 0 is presented twice in total.
REQ-035 nvdla_core_rstn asserted while evt_vld=1 and pend=4'b0110 -> evt_vld, evt_pend and evt_ovf are 0 immediately, asynchronously.
